// File: rtl/gcttt_pkg.sv
// Shared widths, defaults and the fetch-entry type used by the fetch unit.
package gcttt_pkg;

    localparam int PC_W   = 16;
    localparam int INST_W = 16;
    localparam int OPC_W  = 4;

    localparam logic [OPC_W-1:0] OPC_HALT         = 4'hF;
    localparam logic [PC_W-1:0]  RESET_PC_DEFAULT = 16'h0000;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry fetch buffer: OUT register presented to decode plus one skid entry.
module fetch_skid_buf
    import gcttt_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic         out_valid,
    output fetch_entry_t out_entry,
    output logic         skid_valid
);

    fetch_entry_t skid_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_entry  <= '0;
            skid_entry <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || pop) begin
            // OUT is free this edge: the older skid entry takes priority over new data
            if (skid_valid) begin
                out_entry  <= skid_entry;
                out_valid  <= 1'b1;
                skid_valid <= push;
                if (push) begin
                    skid_entry <= push_entry;
                end
            end else begin
                out_valid <= push;
                if (push) begin
                    out_entry <= push_entry;
                end
            end
        end else if (push) begin
            skid_valid <= 1'b1;
            skid_entry <= push_entry;
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch unit with a two-entry output buffer and redirect handling.
// Optional halt-on-opcode behaviour is built when FETCH_HALT_EN is defined.
module fetch
    import gcttt_pkg::*;
#(
    parameter logic [PC_W-1:0]  RESET_PC    = RESET_PC_DEFAULT,
    parameter logic [OPC_W-1:0] HALT_OPCODE = OPC_HALT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              id_stall,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [PC_W-1:0]   if_pc,
    output logic [PC_W-1:0]   if_pc_plus2,
    output logic              halted
);

    logic [PC_W-1:0] fetch_pc;
    logic            inflight;
    logic            out_valid;
    logic            skid_valid;
    fetch_entry_t    out_entry;
    fetch_entry_t    push_entry;
    logic            push;
    logic            pop;
    logic [1:0]      occupancy;
    logic [1:0]      occupancy_after_pop;
    logic            drop_q;

`ifdef FETCH_HALT_EN
    logic halted_q;
    logic halt_hit;

    assign halt_hit = push && (imem_rdata[INST_W-1 -: OPC_W] == HALT_OPCODE);
    assign halted   = halted_q;

    // A request issued in the same cycle the halt word arrives must not be delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            if (redirect_valid) begin
                halted_q <= 1'b0;
            end else if (halt_hit) begin
                halted_q <= 1'b1;
            end
            drop_q <= (drop_q && !(imem_rvalid && inflight)) || (halt_hit && imem_req);
        end
    end
`else
    assign drop_q = 1'b0;
    assign halted = 1'b0;
`endif

    // Requests are never issued during a redirect, so the only response that can be
    // outstanding at redirect time arrives in that same cycle and is gated here.
    assign push = imem_rvalid && inflight && !drop_q && !redirect_valid;
    assign pop  = out_valid && !id_stall;

    assign push_entry.inst = imem_rdata;
    assign push_entry.pc   = fetch_pc - PC_W'(2);

    assign occupancy           = 2'(out_valid) + 2'(skid_valid) + 2'(inflight);
    assign occupancy_after_pop = occupancy - 2'(pop);

    assign imem_req  = rst_n && !redirect_valid && !halted && (occupancy_after_pop < 2'd2);
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (imem_req) begin
                fetch_pc <= fetch_pc + PC_W'(2);
            end
        end
    end

    fetch_skid_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .out_valid  (out_valid),
        .out_entry  (out_entry),
        .skid_valid (skid_valid)
    );

    assign if_valid    = out_valid;
    assign if_inst     = out_entry.inst;
    assign if_pc       = out_entry.pc;
    assign if_pc_plus2 = out_entry.pc + PC_W'(2);

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: first fetch address after reset.
REQ-002 Parameter HALT_OPCODE, default 4'hF: opcode that halts fetch when FETCH_HALT_EN is defined.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction-memory read request this cycle.
REQ-006 imem_addr  output  16  byte address of request; equals fetch_pc.
REQ-007 imem_rvalid  input  1  read data valid; fixed one cycle after an accepted imem_req.
REQ-008 imem_rdata  input  16  instruction word.
REQ-009 id_stall  input  1  decode cannot accept; holds if_* outputs.
REQ-010 redirect_valid  input  1  taken jump/branch from decode/control.
REQ-011 redirect_pc  input  16  redirect target.
REQ-012 if_valid  output  1  if_inst/if_pc/if_pc_plus2 valid for decode.
REQ-013 if_inst  output  16  fetched instruction; decode takes [15:3].
REQ-014 if_pc  output  16  address of if_inst.
REQ-015 if_pc_plus2  output  16  if_pc + 2, modulo 2^16.
REQ-016 halted  output  1  fetch halted; constant 0 without FETCH_HALT_EN.

Function
REQ-017 Storage: output register (OUT) plus one-entry skid (SKID); each holds inst and pc.
REQ-018 Occupancy = OUT valid + SKID valid + in-flight request (0 or 1).
REQ-019 imem_req = !redirect_valid && !halted && (occupancy - (if_valid && !id_stall)) < 2.
REQ-020 Each issued request: fetch_pc <= fetch_pc + 2; 16'hFFFE wraps to 16'h0000.
REQ-021 Response written to OUT if OUT empty or consumed this cycle and SKID empty; otherwise to SKID.
REQ-022 Consume: if_valid && !id_stall; SKID then moves to OUT same edge.
REQ-023 While id_stall=1 with if_valid=1, all if_* outputs SHALL be stable.
REQ-024 No response SHALL ever be lost or duplicated; order equals request order.
REQ-025 redirect_valid (overrides id_stall): clear OUT and SKID, mark in-flight response for drop, fetch_pc <= redirect_pc.
REQ-026 Redirect latency: redirect at cycle N -> imem_req with imem_addr=redirect_pc at N+1 -> if_valid at N+2.
REQ-027 Dropped response SHALL NOT reach OUT/SKID; drop flag clears after that response.
REQ-028 Redirect in same cycle as response: response dropped.
REQ-029 if_pc_plus2 combinational from if_pc.

Reset
REQ-030 rst_n low: fetch_pc=RESET_PC, OUT/SKID invalid, drop flag=0, halted=0, imem_req=0, if_valid=0; if_inst/if_pc=0.
REQ-031 Reset asserted mid-request: in-flight response after deassertion ignored (drop flag set at reset release if imem_rvalid seen).
REQ-032 First imem_req on the first clk edge after rst_n deasserts.

Configuration
REQ-033 Macro FETCH_HALT_EN: response with inst[15:12]==HALT_OPCODE enters pipeline normally, sets halted, marks any in-flight response for drop; halted cleared only by redirect_valid or reset.
REQ-034 Without FETCH_HALT_EN: no halt logic, halted tied 0, HALT_OPCODE unused.

Structure
REQ-035 Shared package gcttt_pkg: PC_W=16, INST_W=16, OPC_W=4, OPC_HALT, RESET_PC_DEFAULT, fetch-entry struct {inst, pc}.
REQ-036 One sub-module fetch_skid_buf: OUT+SKID two-entry buffer with push/pop/flush and valid flags.

Verification
REQ-037 Reset release, no stall, memory returns 16'h1000,16'h2000,... -> imem_addr 0,2,4; if_pc 0,2,4 on consecutive cycles from cycle 2; if_pc_plus2 2,4,6.
REQ-038 id_stall high 3 cycles at if_pc=4 -> if_* held at pc 4; at most 2 extra entries buffered; after release pcs 6,8 with no gap or duplicate.
REQ-039 redirect_valid with redirect_pc=16'h0040 while request in flight -> in-flight data dropped; imem_addr=16'h0040 next cycle; if_pc=16'h0040 two cycles after redirect.
REQ-040 redirect_pc=16'hFFFC, run 3 fetches -> pcs FFFC, FFFE, 0000; if_pc_plus2 at FFFE is 0000.
REQ-041 FETCH_HALT_EN, inst 16'hF000 at pc 8 -> pc 8 delivered, halted=1, pc A dropped, imem_req=0; redirect to 16'h0000 clears halted.
REQ-042 rst_n pulsed low during stalled, full buffer -> if_valid=0 immediately; restart at RESET_PC.
